// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART serial transmitter with a small show-ahead FIFO on the host side.
//   Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits(1). Every bit lasts exactly CLKS_PER_BIT clocks.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   data_in     word to transmit
//   data_valid  data_in is valid; written when data_valid && data_ready
//   data_ready  FIFO not full (decoded from the registered count)
//   tx          serial line, idle high, registered
//   busy        a frame is in progress (FSM not in IDLE)
//   fifo_count  number of words currently queued
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = 4;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;
    logic [DATA_BITS-1:0] w_head;

    assign data_ready  = (r_count != FULL_CNT);
    assign fifo_count  = r_count;
    assign w_push      = data_valid && data_ready;
    assign w_not_empty = (r_count != '0);
    // Show-ahead: the head word is always visible, so the FSM can load and
    // pop it in the same cycle.
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------- FSM
    state_t               r_state;
    logic [BW-1:0]        r_baud;
    logic [NW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;

    state_t               w_state_next;
    logic [BW-1:0]        w_baud_next;
    logic [NW-1:0]        w_bit_cnt_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_parity_next;
    logic                 w_tx_next;
    logic                 w_tick;

    assign w_tick = (r_baud == BAUD_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = w_tick ? '0 : r_baud + BW'(1);
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (w_not_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_head;
                    w_parity_next  = 1'b0;
                    w_bit_cnt_next = '0;
                    w_state_next   = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_parity_next = r_parity ^ r_shift[0];
                    w_shift_next  = r_shift >> 1;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + NW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        // Chain straight into the next frame when words wait,
                        // so back-to-back frames have no idle gap.
                        w_bit_cnt_next = '0;
                        if (w_not_empty) begin
                            w_pop         = 1'b1;
                            w_shift_next  = w_head;
                            w_parity_next = 1'b0;
                            w_state_next  = S_START;
                        end else begin
                            w_state_next  = S_IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + NW'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: tx is registered, so it is decoded from the next state
    // and lines up exactly with the state it belongs to.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = (PARITY == 1) ? ~w_parity_next : w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    // Channel 0: 8N1 /4, channel 1: 7O2 /4, channel 2: 7E2 /4, channel 3: 8N1 /2
    localparam int CLK_OF [4] = '{4, 4, 4, 2};
    localparam int NB_OF  [4] = '{10, 11, 11, 10};

    typedef struct packed {
        logic        contig;
        logic [15:0] bits;   // bit i = i-th bit on the line (bit 0 = start)
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  dv;
    logic [8:0]  din0;
    logic [6:0]  din1;
    logic [6:0]  din2;
    logic [8:0]  din3;
    wire  [3:0]  rdy_w;
    wire  [3:0]  tx_w;
    wire  [3:0]  busy_w;
    wire  [11:0] cnt_flat;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(din0), .data_valid(dv[0]), .data_ready(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_flat[2:0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(din1), .data_valid(dv[1]), .data_ready(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_flat[5:3]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(din2), .data_valid(dv[2]), .data_ready(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_flat[8:6]));
    uart_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst_n(rst_n), .data_in(din3), .data_valid(dv[3]), .data_ready(rdy_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_flat[11:9]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [2:0] cnt_of(input int ch);
        return cnt_flat[ch*3 +: 3];
    endfunction

    task automatic exp_add(input int ch, input logic [15:0] bits, input logic contig);
        exp_t e;
        e.bits   = bits;
        e.contig = contig;
        case (ch)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic set_din(input int ch, input logic [8:0] v);
        case (ch)
            0:       din0 = v;
            1:       din1 = v[6:0];
            2:       din2 = v[6:0];
            default: din3 = v;
        endcase
    endtask

    // One-cycle push; returns 1 ns after the accepting edge. data_in is then
    // scrambled to show that an accepted word is held internally.
    task automatic push(input int ch, input logic [8:0] v);
        @(negedge clk);
        chk($sformatf("ch%0d_ready_0x%0h", ch, v), 32'(rdy_w[ch]), 32'd1);
        set_din(ch, v);
        dv[ch] = 1'b1;
        @(posedge clk);
        #1;
        dv[ch] = 1'b0;
        set_din(ch, ~v);
    endtask

    task automatic wait_drain(input int ch, input int budget);
        int n;
        n = 0;
        while ((qsize(ch) != 0 || busy_w[ch]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ch%0d_drained_in_time", ch), 32'(n < budget), 32'd1);
    endtask

    // Line monitor: samples every channel mid-cycle, captures each frame bit
    // by bit, checks every bit is stable for its full period, then compares
    // against the next expected frame and, where flagged, checks that the
    // frame started on the cycle right after the previous one ended.
    initial begin : monitor
        int   m_cnt   [4];
        int   m_start [4];
        int   m_end   [4];
        bit   m_on    [4];
        bit   m_prev  [4];
        bit   m_jit   [4];
        logic [15:0] m_cap [4];
        exp_t e;
        bit   got;
        int   bi;
        for (int ch = 0; ch < 4; ch++) begin
            m_on[ch] = 0; m_prev[ch] = 0; m_cnt[ch] = 0; m_cap[ch] = '0;
            m_start[ch] = 0; m_end[ch] = 0; m_jit[ch] = 0;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                if (!rst_n) begin
                    m_on[ch]   = 0;
                    m_prev[ch] = 0;
                end else begin
                    if (!m_on[ch] && tx_w[ch] == 1'b0) begin
                        m_on[ch]    = 1;
                        m_cnt[ch]   = 0;
                        m_cap[ch]   = '0;
                        m_jit[ch]   = 0;
                        m_start[ch] = cyc;
                    end
                    if (m_on[ch]) begin
                        bi = m_cnt[ch] / CLK_OF[ch];
                        if (m_cnt[ch] % CLK_OF[ch] == 0) m_cap[ch][bi] = tx_w[ch];
                        else if (m_cap[ch][bi] != tx_w[ch]) m_jit[ch] = 1;
                        m_cnt[ch]++;
                        if (m_cnt[ch] == NB_OF[ch] * CLK_OF[ch]) begin
                            got = 0;
                            e   = '0;
                            case (ch)
                                0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1; end
                                1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1; end
                                2: if (q2.size() != 0) begin e = q2.pop_front(); got = 1; end
                                default: if (q3.size() != 0) begin e = q3.pop_front(); got = 1; end
                            endcase
                            n_vec++;
                            if (!got) begin
                                n_err++;
                                $display("FAIL ch%0d_unexpected_frame: got 0x%0h, expected no frame", ch, m_cap[ch]);
                            end else if (m_jit[ch] || m_cap[ch] !== e.bits) begin
                                n_err++;
                                $display("FAIL ch%0d_frame: got 0x%0h (unstable=%0d), expected 0x%0h",
                                         ch, m_cap[ch], m_jit[ch], e.bits);
                            end else begin
                                $display("ok   ch%0d_frame = 0x%0h", ch, m_cap[ch]);
                            end
                            if (got && e.contig) begin
                                n_vec++;
                                if (!m_prev[ch] || m_start[ch] != m_end[ch] + 1) begin
                                    n_err++;
                                    $display("FAIL ch%0d_contiguous: got start %0d, expected %0d",
                                             ch, m_start[ch], m_end[ch] + 1);
                                end else begin
                                    $display("ok   ch%0d_contiguous start=%0d", ch, m_start[ch]);
                                end
                            end
                            m_end[ch]  = cyc;
                            m_prev[ch] = 1;
                            m_on[ch]   = 0;
                        end
                    end
                end
            end
        end
    end

    // Hand-computed frames for 8N1: {stop, data, start} -> 0x200 | (d << 1)
    logic [15:0] fill_frames [6];

    initial begin : stim
        int n;
        int bc;
        fill_frames = '{16'h0222, 16'h0224, 16'h0226, 16'h0228, 16'h022A, 16'h022C};
        rst_n = 1'b0;
        dv    = '0;
        din0  = '0; din1 = '0; din2 = '0; din3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_a", 32'(tx_w[0]), 32'd1);
        chk("rst_busy_a", 32'(busy_w[0]), 32'd0);
        chk("rst_ready_a", 32'(rdy_w[0]), 32'd1);
        for (int ch = 0; ch < 4; ch++)
            chk($sformatf("rst_count_ch%0d", ch), 32'(cnt_of(ch)), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx_all", 32'(tx_w), 32'hF);

        // Single 8N1 frame, 0xA5
        exp_add(0, 16'h034A, 1'b0);
        push(0, 9'h0A5);
        chk("t1_tx_after_push", 32'(tx_w[0]), 32'd1);
        chk("t1_count_after_push", 32'(cnt_of(0)), 32'd1);
        chk("t1_busy_after_push", 32'(busy_w[0]), 32'd0);
        @(posedge clk); #1;
        chk("t1_tx_start", 32'(tx_w[0]), 32'd0);
        chk("t1_busy_start", 32'(busy_w[0]), 32'd1);
        chk("t1_count_popped", 32'(cnt_of(0)), 32'd0);
        bc = 0; n = 0;
        while (busy_w[0] && n < 200) begin
            @(negedge clk);
            if (busy_w[0]) bc++;
            n++;
        end
        chk("t1_busy_cycles", 32'(bc), 32'd40);
        wait_drain(0, 200);

        // 7-bit, odd (ch1) and even (ch2) parity, two stop bits
        exp_add(1, 16'h0706, 1'b0);   // 0x03 odd  -> parity 1
        exp_add(1, 16'h060E, 1'b1);   // 0x07 odd  -> parity 0
        exp_add(2, 16'h0606, 1'b0);   // 0x03 even -> parity 0
        exp_add(2, 16'h070E, 1'b1);   // 0x07 even -> parity 1
        push(1, 9'h003);
        push(1, 9'h007);
        push(2, 9'h003);
        push(2, 9'h007);
        wait_drain(1, 400);
        wait_drain(2, 400);

        // FIFO fill and back-pressure: hold data_valid high with 0x11..0x16
        @(negedge clk);
        dv[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            din0 = 9'(8'h11 + k);
            if (k == 5) begin
                chk("t3_count_full", 32'(cnt_of(0)), 32'd4);
                chk("t3_ready_full", 32'(rdy_w[0]), 32'd0);
            end
            n = 0;
            while (!rdy_w[0] && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("t3_slot_free_%0d", k), 32'(n < 400), 32'd1);
            exp_add(0, fill_frames[k], k != 0);
            @(negedge clk);
        end
        dv[0] = 1'b0;
        wait_drain(0, 600);

        // Simultaneous push and pop
        exp_add(0, 16'h0278, 1'b0);   // 0x3C
        exp_add(0, 16'h0386, 1'b1);   // 0xC3
        exp_add(0, 16'h02B4, 1'b1);   // 0x5A
        push(0, 9'h03C);
        push(0, 9'h0C3);              // coincides with the pop of 0x3C
        chk("t4_count_first_pop", 32'(cnt_of(0)), 32'd1);
        repeat (39) @(posedge clk);
        push(0, 9'h05A);              // coincides with the end-of-STOP pop of 0xC3
        chk("t4_count_stop_pop", 32'(cnt_of(0)), 32'd1);
        chk("t4_busy_stop_pop", 32'(busy_w[0]), 32'd1);
        wait_drain(0, 400);

        // Reset mid-frame during data bit 3 with two words queued
        push(0, 9'h001);
        push(0, 9'h002);
        push(0, 9'h003);
        chk("t5_count_queued", 32'(cnt_of(0)), 32'd2);
        repeat (16) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx_in_reset", 32'(tx_w[0]), 32'd1);
        chk("t5_count_in_reset", 32'(cnt_of(0)), 32'd0);
        chk("t5_busy_in_reset", 32'(busy_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_w[0] && !busy_w[0]) bc++;
        end
        chk("t5_idle_cycles_after_reset", 32'(bc), 32'd100);
        chk("t5_ready_after_reset", 32'(rdy_w[0]), 32'd1);

        // Divisor of 2: 0xFF then 0x00, contiguous
        exp_add(3, 16'h03FE, 1'b0);
        exp_add(3, 16'h0200, 1'b1);
        push(3, 9'h0FF);
        push(3, 9'h000);
        wait_drain(3, 200);
        chk("t6_count_end", 32'(cnt_of(3)), 32'd0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
